reg_status_file: RTL and testbench
==================================

// Module: reg_status_file
// PURPOSE
//  Architectural register file plus rename-status table for the Tomasulo core.
//  It is the receiving end of the ROB commit port: it retires committed results
//  and clears rename tags.
//  It also serves decoder operand lookups (value, or busy + producing ROB tag),
//  records new rename tags on issue, and drops all rename state on an ROB flush.
// PARAMETERS
//  REG_NUM  32  number of architectural registers; x0 is hardwired to zero
//  REG_W    5   register index width, log2(REG_NUM)
//  DATA_W   32  register data width
//  TAG_W    4   ROB tag width
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous, active-low reset
//  rdy          in   1       global ready; low = hold all state
//  rs1_decoder  in   REG_W   source register 1 index
//  rs1_busy     out  1       rs1 is awaiting a ROB result
//  rs1_data     out  DATA_W  rs1 value; valid when rs1_busy=0
//  rs1_tag      out  TAG_W   ROB tag producing rs1; valid when rs1_busy=1
//  rs2_decoder  in   REG_W   source register 2 index
//  rs2_busy     out  1       as rs1_busy, for rs2
//  rs2_data     out  DATA_W  as rs1_data, for rs2
//  rs2_tag      out  TAG_W   as rs1_tag, for rs2
//  if_issue     in   1       decoder issues an instruction that writes rd_decoder
//  rd_decoder   in   REG_W   destination register of the issued instruction
//  tag_issue    in   TAG_W   ROB tag allocated to the issued instruction
//  if_commit    in   1       ROB commits a register write
//  pos_commit   in   REG_W   committed destination register
//  data_commit  in   DATA_W  committed value
//  tag_commit   in   TAG_W   ROB tag of the committing entry
//  if_flush     in   1       ROB misprediction flush (ROB if_jump)
// BEHAVIOUR
//  - State per register: data[DATA_W], busy, tag[TAG_W].
//  - Reset (rst=0 at a clock edge): all data, busy and tag cleared. rst has
//    priority over rdy.
//  - rdy=0: no state updates. Read outputs still track current state.
//  - Read ports are combinational, zero latency.
//    - Index 0 always gives busy=0, data=0, tag=0.
//    - Otherwise they report the stored busy/data/tag.
//    - Commit bypass: if if_commit=1, pos_commit==rsX, the register is busy and
//      tag_commit==stored tag, the read reports busy=0 and data=data_commit in
//      the same cycle.
//  - Commit, at the clock edge:
//    - If pos_commit!=0, data[pos_commit] <= data_commit unconditionally.
//    - busy is cleared only if busy=1 and stored tag==tag_commit. A newer
//      rename that has already replaced the tag stays busy.
//  - Issue, at the clock edge: if rd_decoder!=0 and if_flush=0,
//    busy[rd] <= 1 and tag[rd] <= tag_issue.
//  - Same cycle, same register, issue + commit: data is written, the issue tag
//    is installed, and busy stays 1. Issue wins over the commit clear.
//  - Both read and issue on the same register in one cycle: reads see the
//    pre-issue state, because an instruction never depends on its own rd.
//  - Flush:
//    - All busy bits clear at the edge. Tags are left stale and are don't-care.
//    - A commit in the same cycle still writes its data, since it is older
//      than the flush.
//    - A same-cycle issue is dropped.
//  - Writes to x0 (issue or commit) are ignored; x0 is never busy.
//  - There is no handshake and no backpressure. Every valid strobe is
//    accepted in its cycle while rdy=1.
// TESTING
//  1. Reset, then read x5/x0 -> busy=0, data=0 for both.
//  2. Issue rd=5, tag=3, then read rs1=5 -> busy=1, tag=3.
//     Next, commit pos=5, tag=3, data=0xDEADBEEF -> same-cycle read shows
//     busy=0, data=0xDEADBEEF. After the edge the stored value stays, busy=0.
//  3. Issue x7 with tag=2, then issue x7 with tag=9, then commit x7 with tag=2
//     and data=0x11 -> data=0x11 stored, x7 still busy with tag=9, and the
//     bypass is not applied.
//  4. Same cycle: commit x4 (tag=1, data=0x22) and issue x4 (tag=6) -> x4
//     busy=1, tag=6, data=0x22.
//  5. Make x1..x3 busy, then pulse if_flush with commit x2 (data=0x33) and
//     issue x8 -> x1..x3 and x8 not busy, x2 data=0x33.
//  6. Hold rdy=0 while issuing x9 and committing x10 -> no change. Issue or
//     commit to x0 -> x0 reads busy=0, data=0.

Source files
------------

// File: rtl/reg_status_file_if.sv
// Decoder/ROB-facing bus of the architectural register file and rename-status table.
// The master side drives lookups, issue, commit and flush; the slave side is the register file.
interface reg_status_file_if #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic [REG_W-1:0]  rs1_decoder;
    logic              rs1_busy;
    logic [DATA_W-1:0] rs1_data;
    logic [TAG_W-1:0]  rs1_tag;

    logic [REG_W-1:0]  rs2_decoder;
    logic              rs2_busy;
    logic [DATA_W-1:0] rs2_data;
    logic [TAG_W-1:0]  rs2_tag;

    logic              if_issue;
    logic [REG_W-1:0]  rd_decoder;
    logic [TAG_W-1:0]  tag_issue;

    logic              if_commit;
    logic [REG_W-1:0]  pos_commit;
    logic [DATA_W-1:0] data_commit;
    logic [TAG_W-1:0]  tag_commit;

    logic              if_flush;

    modport master (
        output rs1_decoder, rs2_decoder,
        output if_issue, rd_decoder, tag_issue,
        output if_commit, pos_commit, data_commit, tag_commit,
        output if_flush,
        input  rs1_busy, rs1_data, rs1_tag,
        input  rs2_busy, rs2_data, rs2_tag
    );

    modport slave (
        input  rs1_decoder, rs2_decoder,
        input  if_issue, rd_decoder, tag_issue,
        input  if_commit, pos_commit, data_commit, tag_commit,
        input  if_flush,
        output rs1_busy, rs1_data, rs1_tag,
        output rs2_busy, rs2_data, rs2_tag
    );
endinterface

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + producing ROB tag).
// Retires ROB commits, records rename tags on issue and drops all renames on a flush.
module reg_status_file #(
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4
) (
    input logic              clk,
    input logic              rst,
    input logic              rdy,
    reg_status_file_if.slave bus
);

    logic [DATA_W-1:0] data_q [REG_NUM];
    logic              busy_q [REG_NUM];
    logic [TAG_W-1:0]  tag_q  [REG_NUM];

    logic [REG_W-1:0]  rd_idx  [2];
    logic              rd_busy [2];
    logic [DATA_W-1:0] rd_data [2];
    logic [TAG_W-1:0]  rd_tag  [2];

    logic commit_valid;
    logic commit_clears;
    logic issue_valid;

    assign rd_idx[0] = bus.rs1_decoder;
    assign rd_idx[1] = bus.rs2_decoder;

    // Reads see pre-edge state, except that a matching commit is forwarded in the same cycle.
    for (genvar p = 0; p < 2; p++) begin : g_read
        always_comb begin
            rd_busy[p] = 1'b0;
            rd_data[p] = '0;
            rd_tag[p]  = '0;
            if (rd_idx[p] != '0) begin
                rd_busy[p] = busy_q[rd_idx[p]];
                rd_data[p] = data_q[rd_idx[p]];
                rd_tag[p]  = tag_q[rd_idx[p]];
                if (bus.if_commit && (bus.pos_commit == rd_idx[p]) &&
                    busy_q[rd_idx[p]] && (tag_q[rd_idx[p]] == bus.tag_commit)) begin
                    rd_busy[p] = 1'b0;
                    rd_data[p] = bus.data_commit;
                end
            end
        end
    end

    assign bus.rs1_busy = rd_busy[0];
    assign bus.rs1_data = rd_data[0];
    assign bus.rs1_tag  = rd_tag[0];
    assign bus.rs2_busy = rd_busy[1];
    assign bus.rs2_data = rd_data[1];
    assign bus.rs2_tag  = rd_tag[1];

    assign commit_valid  = bus.if_commit && (bus.pos_commit != '0);
    assign commit_clears = commit_valid && busy_q[bus.pos_commit] &&
                           (tag_q[bus.pos_commit] == bus.tag_commit);
    assign issue_valid   = bus.if_issue && (bus.rd_decoder != '0) && !bus.if_flush;

    // Later assignments win: flush clear, then commit clear, then issue set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy) begin
            if (bus.if_flush) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    busy_q[i] <= 1'b0;
                end
            end
            if (commit_valid) begin
                data_q[bus.pos_commit] <= bus.data_commit;
            end
            if (commit_clears) begin
                busy_q[bus.pos_commit] <= 1'b0;
            end
            if (issue_valid) begin
                busy_q[bus.rd_decoder] <= 1'b1;
                tag_q[bus.rd_decoder]  <= bus.tag_issue;
            end
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: a rule-level model of the register/rename state is
// checked against both read ports every cycle, plus literal expectations for key scenarios.
module tb_reg_status_file;

    logic clk;
    logic rst;
    logic rdy;
    bit   check_en;
    int   total;
    int   bad;

    logic [31:0] m_data [32];
    bit          m_busy [32];
    logic [3:0]  m_tag  [32];

    reg_status_file_if #(.REG_W(5), .DATA_W(32), .TAG_W(4)) bus ();

    reg_status_file #(.REG_NUM(32), .REG_W(5), .DATA_W(32), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What a lookup must return: x0 is constant zero, a matching commit is forwarded.
    task automatic expRead(input logic [4:0] idx, output bit b, output logic [31:0] d,
                           output logic [3:0] t);
        b = 1'b0;
        d = 32'h0;
        t = 4'h0;
        if (idx != 5'd0) begin
            b = m_busy[idx];
            d = m_data[idx];
            t = m_tag[idx];
            if (bus.if_commit && bus.pos_commit == idx && m_busy[idx] && m_tag[idx] == bus.tag_commit) begin
                b = 1'b0;
                d = bus.data_commit;
            end
        end
    endtask

    // Architectural effect of one clock edge.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = 32'h0;
                m_busy[i] = 1'b0;
                m_tag[i]  = 4'h0;
            end
        end else if (rdy) begin
            bit same_commit_hit;
            same_commit_hit = bus.if_commit && bus.pos_commit != 5'd0 &&
                              m_busy[bus.pos_commit] && m_tag[bus.pos_commit] == bus.tag_commit;
            if (bus.if_commit && bus.pos_commit != 5'd0) m_data[bus.pos_commit] = bus.data_commit;
            if (same_commit_hit) m_busy[bus.pos_commit] = 1'b0;
            if (bus.if_flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (bus.if_issue && bus.rd_decoder != 5'd0) begin
                m_busy[bus.rd_decoder] = 1'b1;
                m_tag[bus.rd_decoder]  = bus.tag_issue;
            end
        end
    end

    // Every cycle: both read ports against the model; data only when idle, tag only when busy.
    always @(negedge clk) begin
        if (check_en) begin
            bit          b1, b2;
            logic [31:0] d1, d2;
            logic [3:0]  t1, t2;
            expRead(bus.rs1_decoder, b1, d1, t1);
            expRead(bus.rs2_decoder, b2, d2, t2);
            checkOutput("rs1_busy", {31'h0, bus.rs1_busy}, {31'h0, b1});
            checkOutput("rs2_busy", {31'h0, bus.rs2_busy}, {31'h0, b2});
            if (!b1) checkOutput("rs1_data", bus.rs1_data, d1);
            else     checkOutput("rs1_tag", {28'h0, bus.rs1_tag}, {28'h0, t1});
            if (!b2) checkOutput("rs2_data", bus.rs2_data, d2);
            else     checkOutput("rs2_tag", {28'h0, bus.rs2_tag}, {28'h0, t2});
        end
    end

    // Commits the previous cycle's inputs, drives the new ones, then parks just after the
    // falling edge so the same-cycle combinational reads can be inspected.
    task automatic applyStimulus(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input bit iss, input logic [4:0] rd, input logic [3:0] ti,
                                 input bit cmt, input logic [4:0] pos, input logic [31:0] dc,
                                 input logic [3:0] tc, input bit fl);
        @(posedge clk);
        #1;
        rdy             = r;
        bus.rs1_decoder = rs1;
        bus.rs2_decoder = rs2;
        bus.if_issue    = iss;
        bus.rd_decoder  = rd;
        bus.tag_issue   = ti;
        bus.if_commit   = cmt;
        bus.pos_commit  = pos;
        bus.data_commit = dc;
        bus.tag_commit  = tc;
        bus.if_flush    = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic pinRead(input string name, input bit b1, input logic [31:0] d1,
                           input bit b2, input logic [31:0] d2);
        checkOutput({name, "_rs1_busy"}, {31'h0, bus.rs1_busy}, {31'h0, b1});
        checkOutput({name, "_rs1_data"}, bus.rs1_data, d1);
        checkOutput({name, "_rs2_busy"}, {31'h0, bus.rs2_busy}, {31'h0, b2});
        checkOutput({name, "_rs2_data"}, bus.rs2_data, d2);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        check_en = 1'b0;
        rst = 1'b0;
        rdy = 1'b1;
        bus.rs1_decoder = '0; bus.rs2_decoder = '0;
        bus.if_issue = 1'b0;  bus.rd_decoder = '0;  bus.tag_issue = '0;
        bus.if_commit = 1'b0; bus.pos_commit = '0;  bus.data_commit = '0; bus.tag_commit = '0;
        bus.if_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_en = 1'b1;

        // Reset state
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        pinRead("reset", 0, 32'h0, 0, 32'h0);

        // Rename, then retire through the bypass
        applyStimulus(1, 5, 0, 1, 5, 3, 0, 0, 32'h0, 0, 0);
        checkOutput("issue_same_cycle_busy", {31'h0, bus.rs1_busy}, 32'h0);
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("x5_busy", {31'h0, bus.rs1_busy}, 32'h1);
        checkOutput("x5_tag", {28'h0, bus.rs1_tag}, 32'h3);
        applyStimulus(1, 5, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 3, 0);
        pinRead("bypass", 0, 32'hDEADBEEF, 0, 32'h0);
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        pinRead("x5_retired", 0, 32'hDEADBEEF, 0, 32'h0);

        // Stale commit against a newer rename
        applyStimulus(1, 7, 0, 1, 7, 2, 0, 0, 32'h0, 0, 0);
        applyStimulus(1, 7, 0, 1, 7, 9, 0, 0, 32'h0, 0, 0);
        applyStimulus(1, 7, 0, 0, 0, 0, 1, 7, 32'h11, 2, 0);
        checkOutput("stale_no_bypass", {31'h0, bus.rs1_busy}, 32'h1);
        applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("x7_still_busy", {31'h0, bus.rs1_busy}, 32'h1);
        checkOutput("x7_tag", {28'h0, bus.rs1_tag}, 32'h9);

        // Same-cycle commit and issue on x4
        applyStimulus(1, 4, 0, 1, 4, 6, 1, 4, 32'h22, 1, 0);
        applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("x4_busy", {31'h0, bus.rs1_busy}, 32'h1);
        checkOutput("x4_tag", {28'h0, bus.rs1_tag}, 32'h6);

        // Flush with an older commit and a dropped issue
        applyStimulus(1, 0, 0, 1, 1, 1, 0, 0, 32'h0, 0, 0);
        applyStimulus(1, 0, 0, 1, 2, 2, 0, 0, 32'h0, 0, 0);
        applyStimulus(1, 0, 0, 1, 3, 3, 0, 0, 32'h0, 0, 0);
        applyStimulus(1, 2, 8, 1, 8, 5, 1, 2, 32'h33, 2, 1);
        applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        pinRead("flush_x1_x2", 0, 32'h0, 0, 32'h33);
        applyStimulus(1, 3, 8, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        pinRead("flush_x3_x8", 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 7, 4, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        pinRead("flush_x7_x4", 0, 32'h11, 0, 32'h22);

        // Hold while not ready, then x0 writes
        applyStimulus(0, 9, 10, 1, 9, 4, 1, 10, 32'h55, 0, 0);
        applyStimulus(0, 9, 10, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        applyStimulus(1, 9, 10, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        pinRead("hold", 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 0, 1, 0, 7, 1, 0, 32'h99, 7, 0);
        pinRead("x0_write_cycle", 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        pinRead("x0_after", 0, 32'h0, 0, 32'hDEADBEEF);

        // Reset while not ready still clears everything
        applyStimulus(1, 0, 0, 1, 6, 2, 0, 0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        check_en = 1'b0;
        rst = 1'b0;
        rdy = 1'b0;
        bus.if_issue = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_en = 1'b1;
        applyStimulus(1, 6, 5, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        pinRead("reset_over_rdy", 0, 32'h0, 0, 32'h0);

        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
